mux_8by1_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one 8:1 single-bit mux between 8 requesters.
//  - Picks a requester and drives the mux select s.
//  - Holds each grant for a bounded burst, then registers the selected input bit onto y.
//  - Sits in front of the MUX_8by1 datapath; the mux is instantiated inside.

---
 rtl/mux_sched_pkg.sv | 21 ++
 rtl/MUX_8by1.sv | 15 +
 rtl/rr_pick8.sv | 28 ++
 rtl/mux_8by1_rr_scheduler.sv | 117 +++++++++++
 tb/tb_mux_8by1_rr_scheduler.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_sched_pkg.sv
// Shared constants for the round-robin 8:1 mux scheduler: requester count,
// select width, FSM state encodings, hold-counter sizing and a select-to-grant helper.
package mux_sched_pkg;

    localparam int N_REQ        = 8;
    localparam int SEL_W        = 3;
    localparam int MAX_HOLD_DEF = 4;
    localparam int HOLD_W       = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    // Convert a select index into the matching one-hot grant vector
    function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] vec;
        vec = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/MUX_8by1.sv
// The existing single-bit 8:1 datapath mux: y is the input selected by s.
import mux_sched_pkg::*;

module MUX_8by1 (
    input  logic [N_REQ-1:0] i,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    // Plain index select; no storage in the datapath itself
    always_comb begin
        y = i[s];
    end

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr (wrapping modulo 8) whose request bit is set.
import mux_sched_pkg::*;

module rr_pick8 (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest hit to ptr wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_8by1_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 mux between 8 requesters. Each grant
// lasts up to MAX_HOLD sampled cycles; the selected bit is registered onto y.
import mux_sched_pkg::*;

module mux_8by1_rr_scheduler #(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] i,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] s,
    output logic             y,
    output logic             y_valid,
    output logic             busy
);

    logic [0:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic             mux_y;
    logic             idle_found;
    logic [SEL_W-1:0] idle_idx;
    logic [N_REQ-1:0] masked_req;
    logic [SEL_W-1:0] next_ptr;
    logic             serve_found;
    logic [SEL_W-1:0] serve_idx;
    logic             sampled;
    logic             last_sample;
    logic             burst_end;

    MUX_8by1 u_mux (
        .i (i),
        .s (s),
        .y (mux_y)
    );

    rr_pick8 u_pick_idle (
        .req   (req),
        .ptr   (ptr),
        .found (idle_found),
        .idx   (idle_idx)
    );

    rr_pick8 u_pick_serve (
        .req   (masked_req),
        .ptr   (next_ptr),
        .found (serve_found),
        .idx   (serve_idx)
    );

    // Burst bookkeeping: the other requesters, the rotated pointer and the end-of-burst condition
    always_comb begin
        masked_req  = req & ~sel_to_onehot(s);
        next_ptr    = s + SEL_W'(1);
        sampled     = req[s];
        last_sample = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
        burst_end   = !sampled || last_sample;
    end

    assign busy = (state == ST_SERVE);

    // FSM, hold counter, pointer and output registers; a reset aborts any burst without sampling
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            s        <= '0;
            y        <= 1'b0;
            y_valid  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    y_valid <= 1'b0;
                    if (idle_found) begin
                        state    <= ST_SERVE;
                        s        <= idle_idx;
                        grant    <= sel_to_onehot(idle_idx);
                        hold_cnt <= '0;
                    end
                end
                ST_SERVE: begin
                    if (sampled) begin
                        y       <= mux_y;
                        y_valid <= 1'b1;
                        if (!last_sample) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end else begin
                        y_valid <= 1'b0;
                    end
                    if (burst_end) begin
                        ptr      <= next_ptr;
                        hold_cnt <= '0;
                        if (serve_found) begin
                            s     <= serve_idx;
                            grant <= sel_to_onehot(serve_idx);
                        end else if (!sampled) begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    grant    <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_8by1_rr_scheduler.sv
// Directed testbench for mux_8by1_rr_scheduler with hand-computed expectations.
module tb_mux_8by1_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] i;
    logic [7:0] grant;
    logic [2:0] s;
    logic       y;
    logic       y_valid;
    logic       busy;

    int errors;
    int checks;

    mux_8by1_rr_scheduler dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .i       (i),
        .grant   (grant),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one rising edge and settle before looking at outputs
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bring the DUT to a clean IDLE state with everything deasserted
    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        i     = 8'h00;
        tick();
        rst_n = 1'b1;
    endtask

    // Reset held for two edges while every requester is asking
    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        i     = 8'hFF;
        tick();
        tick();
        checks++; if (grant !== 8'h00) begin errors++; $display("[TB] FAIL reset_grant got=%h exp=00", grant); end
        checks++; if (s !== 3'd0) begin errors++; $display("[TB] FAIL reset_s got=%0d exp=0", s); end
        checks++; if (y !== 1'b0) begin errors++; $display("[TB] FAIL reset_y got=%b exp=0", y); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_y_valid got=%b exp=0", y_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        req   = 8'h00;
        i     = 8'h00;
    endtask

    // Lone requester 2 is granted, sampled, and re-granted after 4 samples with no gap
    task automatic test_single();
        logic exp_v;
        apply_reset();
        req = 8'b0000_0100;
        i   = 8'b0000_0100;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp_v = (e >= 2);
            checks++; if (s !== 3'd2) begin errors++; $display("[TB] FAIL single_s e=%0d got=%0d exp=2", e, s); end
            checks++; if (grant !== 8'h04) begin errors++; $display("[TB] FAIL single_grant e=%0d got=%h exp=04", e, grant); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy e=%0d got=%b exp=1", e, busy); end
            checks++; if (y_valid !== exp_v) begin errors++; $display("[TB] FAIL single_y_valid e=%0d got=%b exp=%b", e, y_valid, exp_v); end
            checks++; if (y !== exp_v) begin errors++; $display("[TB] FAIL single_y e=%0d got=%b exp=%b", e, y, exp_v); end
        end
        req = 8'h00;
    endtask

    // Everyone requests: 4 samples per grant, select walks 0..7 and wraps to 0
    task automatic test_all_request();
        logic [2:0] exp_s;
        logic [7:0] exp_g;
        logic       exp_v;
        apply_reset();
        req = 8'hFF;
        i   = 8'hFF;
        for (int e = 1; e <= 33; e++) begin
            tick();
            exp_s = 3'(((e - 1) / 4) % 8);
            exp_g = 8'h01 << exp_s;
            exp_v = (e >= 2);
            checks++; if (s !== exp_s) begin errors++; $display("[TB] FAIL all_s e=%0d got=%0d exp=%0d", e, s, exp_s); end
            checks++; if (grant !== exp_g) begin errors++; $display("[TB] FAIL all_grant e=%0d got=%h exp=%h", e, grant, exp_g); end
            checks++; if (y_valid !== exp_v) begin errors++; $display("[TB] FAIL all_y_valid e=%0d got=%b exp=%b", e, y_valid, exp_v); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL all_busy e=%0d got=%b exp=1", e, busy); end
        end
        req = 8'h00;
    endtask

    // Requester 0 drops after 2 samples; 7 takes over with one invalid edge
    task automatic test_early_release();
        apply_reset();
        req = 8'h81;
        i   = 8'h80;
        tick();
        checks++; if (s !== 3'd0) begin errors++; $display("[TB] FAIL early_s0 got=%0d exp=0", s); end
        checks++; if (grant !== 8'h01) begin errors++; $display("[TB] FAIL early_grant0 got=%h exp=01", grant); end
        for (int e = 2; e <= 3; e++) begin
            tick();
            checks++; if (y_valid !== 1'b1) begin errors++; $display("[TB] FAIL early_y_valid e=%0d got=%b exp=1", e, y_valid); end
            checks++; if (y !== 1'b0) begin errors++; $display("[TB] FAIL early_y e=%0d got=%b exp=0", e, y); end
        end
        req = 8'h80;
        tick();
        checks++; if (s !== 3'd7) begin errors++; $display("[TB] FAIL early_s7 got=%0d exp=7", s); end
        checks++; if (grant !== 8'h80) begin errors++; $display("[TB] FAIL early_grant7 got=%h exp=80", grant); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("[TB] FAIL early_gap_y_valid got=%b exp=0", y_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL early_busy got=%b exp=1", busy); end
        tick();
        checks++; if (y_valid !== 1'b1) begin errors++; $display("[TB] FAIL early_resume_y_valid got=%b exp=1", y_valid); end
        checks++; if (y !== 1'b1) begin errors++; $display("[TB] FAIL early_resume_y got=%b exp=1", y); end
        checks++; if (s !== 3'd7) begin errors++; $display("[TB] FAIL early_resume_s got=%0d exp=7", s); end
        req = 8'h00;
    endtask

    // Data walks one-hot with the expected select, so every sample is 1; then all-zero data
    task automatic test_rotating();
        logic [2:0] exp_s;
        apply_reset();
        req = 8'hFF;
        i   = 8'h01;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_s = 3'(((e - 1) / 4) % 8);
            i = 8'h01 << exp_s;
            if (e >= 2) begin
                checks++; if (y !== 1'b1) begin errors++; $display("[TB] FAIL rot_y e=%0d got=%b exp=1", e, y); end
                checks++; if (y_valid !== 1'b1) begin errors++; $display("[TB] FAIL rot_y_valid e=%0d got=%b exp=1", e, y_valid); end
            end
        end
        i = 8'h00;
        tick();
        checks++; if (y !== 1'b0) begin errors++; $display("[TB] FAIL rot_zero_y got=%b exp=0", y); end
        checks++; if (y_valid !== 1'b1) begin errors++; $display("[TB] FAIL rot_zero_y_valid got=%b exp=1", y_valid); end
        req = 8'h00;
    endtask

    // Reset in the middle of the s=5 burst, then the pointer must restart at 0
    task automatic test_mid_reset();
        apply_reset();
        req = 8'hFF;
        i   = 8'hFF;
        for (int e = 1; e <= 22; e++) begin
            tick();
        end
        checks++; if (s !== 3'd5) begin errors++; $display("[TB] FAIL mid_pre_s got=%0d exp=5", s); end
        checks++; if (y !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_y got=%b exp=1", y); end
        rst_n = 1'b0;
        tick();
        checks++; if (grant !== 8'h00) begin errors++; $display("[TB] FAIL mid_grant got=%h exp=00", grant); end
        checks++; if (s !== 3'd0) begin errors++; $display("[TB] FAIL mid_s got=%0d exp=0", s); end
        checks++; if (y !== 1'b0) begin errors++; $display("[TB] FAIL mid_y got=%b exp=0", y); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_y_valid got=%b exp=0", y_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        req   = 8'h21;
        tick();
        checks++; if (s !== 3'd0) begin errors++; $display("[TB] FAIL mid_regrant_s got=%0d exp=0", s); end
        checks++; if (grant !== 8'h01) begin errors++; $display("[TB] FAIL mid_regrant_grant got=%h exp=01", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_regrant_busy got=%b exp=1", busy); end
        req = 8'h00;
    endtask

    // Run every scenario in order, then report
    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        i      = 8'h00;
        test_reset();
        test_single();
        test_all_request();
        test_early_release();
        test_rotating();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
